wb_port: RTL and testbench

Writeback port controller for the single write port of the general register file. Merges single-cycle ALU results and long-latency (load / multiply-divide) results onto one `wen`/`r3`/`WD` write bus. Long-latency results are buffered in a small FIFO. A destination scoreboard tells decode which registers still have a long-latency write outstanding. Sits between the EX/MEM stages and the register file, and feeds the decode-stage stall logic.

---
 rtl/wb_port.sv | 141 ++++++++++++++
 tb/tb_wb_port.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port.sv
// rtl/wb_port.sv - writeback port arbiter: ALU results, buffered long-latency results, destination scoreboard
module wb_port #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  q_rs,
  input  logic [4:0]  q_rt,
  output logic        busy_rs,
  output logic        busy_rt,
  output logic        stall_req,
  output logic        wen,
  output logic [4:0]  r3,
  output logic [31:0] WD
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  // Long-latency result buffer; contents need no reset, pointers/count do.
  logic [4:0]    fifo_rd   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   sb;
  logic [31:0]   sb_next;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;

  logic          push;
  logic          pop;
  logic          alu_win;
  logic          fifo_nonempty;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign mem_ready     = (count != FULL_CNT);
  assign fifo_nonempty = (count != '0);
  assign push          = mem_valid && mem_ready;
  // An ALU result to $0 is dropped and does not take the write slot.
  assign alu_win       = alu_valid && (alu_rd != 5'd0);
  assign pop           = fifo_nonempty && !alu_win;
  assign head_rd       = fifo_rd[rd_ptr];
  assign head_data     = fifo_data[rd_ptr];

  assign busy_rs = sb[q_rs];
  assign busy_rt = sb[q_rt];

  // Buffer storage write on accepted long-latency results.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  // Buffer pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Starvation count of the buffer head; saturates at the stall threshold.
  always_comb begin
    starve_next = starve_cnt;
    if (!fifo_nonempty || pop) begin
      starve_next = '0;
    end else if (alu_win && (starve_cnt != STARVE_TOP)) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  // Starvation counter and registered stall request derived from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_req  <= (starve_next == STARVE_TOP);
    end
  end

  // Scoreboard update: clear on head selection, then issue sets so set wins.
  always_comb begin
    sb_next = sb;
    if (pop && (head_rd != 5'd0)) sb_next[head_rd] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) sb_next[iss_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= sb_next;
  end

  // Registered write bus; address and data hold while idle or on a $0 pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen <= 1'b0;
      r3  <= 5'd0;
      WD  <= 32'd0;
    end else if (alu_win) begin
      wen <= 1'b1;
      r3  <= alu_rd;
      WD  <= alu_data;
    end else if (pop && (head_rd != 5'd0)) begin
      wen <= 1'b1;
      r3  <= head_rd;
      WD  <= head_data;
    end else begin
      wen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port.sv
// tb/tb_wb_port.sv - scoreboard testbench for wb_port
module tb_wb_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  q_rs;
  logic [4:0]  q_rt;
  logic        busy_rs;
  logic        busy_rt;
  logic        stall_req;
  logic        wen;
  logic [4:0]  r3;
  logic [31:0] WD;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;
  logic [36:0] exp_q[$];

  wb_port #(.FIFO_DEPTH(2), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_rs(q_rs), .q_rt(q_rt), .busy_rs(busy_rs), .busy_rt(busy_rt),
    .stall_req(stall_req), .wen(wen), .r3(r3), .WD(WD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  // Monitor: every write on the bus must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && wen) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got r3=%0d WD=0x%0h expected no write", r3, WD);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({r3, WD} !== e) begin
          n_fail++;
          $display("FAIL write_order: got r3=%0d WD=0x%0h expected r3=%0d WD=0x%0h",
                   r3, WD, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    iss_valid = 0; iss_rd = 0; q_rs = 5'd5; q_rt = 5'd7;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("reset_wen", {31'd0, wen}, 32'd0);
    chk("reset_r3", {27'd0, r3}, 32'd0);
    chk("reset_wd", WD, 32'd0);
    chk("reset_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_busy_rs", {31'd0, busy_rs}, 32'd0);

    // ALU write
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
    expect_write(5'd5, 32'h1234_5678);
    tick();
    alu_valid = 0;
    chk("alu_wen", {31'd0, wen}, 32'd1);
    chk("alu_r3", {27'd0, r3}, 32'd5);
    chk("alu_wd", WD, 32'h1234_5678);
    tick();
    chk("alu_wen_drop", {31'd0, wen}, 32'd0);

    // Scoreboard issue and clear
    iss_valid = 1; iss_rd = 5'd8;
    tick();
    iss_valid = 0; q_rs = 5'd8; #1;
    chk("sb8_set", {31'd0, busy_rs}, 32'd1);
    mem_valid = 1; mem_rd = 5'd8; mem_data = 32'hDEAD_BEEF;
    expect_write(5'd8, 32'hDEAD_BEEF);
    tick();
    mem_valid = 0; #1;
    chk("sb8_busy_before_clear", {31'd0, busy_rs}, 32'd1);
    chk("load_wen_not_yet", {31'd0, wen}, 32'd0);
    tick();
    chk("load_wen", {31'd0, wen}, 32'd1);
    chk("load_r3", {27'd0, r3}, 32'd8);
    chk("sb8_cleared", {31'd0, busy_rs}, 32'd0);
    tick();

    // Full FIFO and starvation
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA1;
    mem_valid = 1; mem_rd = 5'd10; mem_data = 32'hAAAA_0001;
    expect_write(5'd1, 32'hA1);
    tick();
    alu_rd = 5'd2; alu_data = 32'hA2;
    mem_rd = 5'd11; mem_data = 32'hBBBB_0002;
    expect_write(5'd2, 32'hA2);
    tick();
    mem_valid = 0; #1;
    chk("full_mem_ready", {31'd0, mem_ready}, 32'd0);
    alu_rd = 5'd3; alu_data = 32'hA3;
    expect_write(5'd3, 32'hA3);
    tick();
    chk("stall_not_yet", {31'd0, stall_req}, 32'd0);
    alu_rd = 5'd4; alu_data = 32'hA4;
    expect_write(5'd4, 32'hA4);
    expect_write(5'd10, 32'hAAAA_0001);
    expect_write(5'd11, 32'hBBBB_0002);
    tick();
    chk("stall_asserted", {31'd0, stall_req}, 32'd1);
    alu_valid = 0;
    tick();
    chk("forced_drain_r3", {27'd0, r3}, 32'd10);
    chk("stall_released", {31'd0, stall_req}, 32'd0);
    chk("ready_after_pop", {31'd0, mem_ready}, 32'd1);
    tick();
    chk("second_drain_r3", {27'd0, r3}, 32'd11);
    tick();

    // Priority: ALU to $0 does not block the FIFO head
    mem_valid = 1; mem_rd = 5'd3; mem_data = 32'h3333_0003;
    expect_write(5'd3, 32'h3333_0003);
    tick();
    mem_valid = 0;
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    tick();
    alu_valid = 0;
    chk("alu_r0_head_wen", {31'd0, wen}, 32'd1);
    chk("alu_r0_head_r3", {27'd0, r3}, 32'd3);

    // FIFO head to $0: popped without a write, scoreboard untouched
    iss_valid = 1; iss_rd = 5'd7;
    tick();
    iss_valid = 0;
    mem_valid = 1; mem_rd = 5'd0; mem_data = 32'h0000_F00D;
    tick();
    mem_valid = 0;
    tick();
    chk("r0_head_no_wen", {31'd0, wen}, 32'd0);
    chk("r0_head_sb7", {31'd0, busy_rt}, 32'd1);
    chk("r0_head_popped", {31'd0, mem_ready}, 32'd1);

    // Same-edge set and clear of r9
    iss_valid = 1; iss_rd = 5'd9;
    tick();
    iss_valid = 0;
    mem_valid = 1; mem_rd = 5'd9; mem_data = 32'h9999_0009;
    expect_write(5'd9, 32'h9999_0009);
    tick();
    mem_valid = 0;
    iss_valid = 1; iss_rd = 5'd9;
    tick();
    iss_valid = 0; q_rs = 5'd9; #1;
    chk("same_edge_r3", {27'd0, r3}, 32'd9);
    chk("same_edge_busy", {31'd0, busy_rs}, 32'd1);
    tick();

    // Reset mid-operation with two queued entries and sb[4] set
    iss_valid = 1; iss_rd = 5'd4;
    alu_valid = 1; alu_rd = 5'd12; alu_data = 32'hC12;
    mem_valid = 1; mem_rd = 5'd4; mem_data = 32'h4444_0001;
    expect_write(5'd12, 32'hC12);
    tick();
    iss_valid = 0;
    alu_rd = 5'd13; alu_data = 32'hC13;
    mem_data = 32'h4444_0002;
    expect_write(5'd13, 32'hC13);
    tick();
    alu_valid = 0; mem_valid = 0; q_rs = 5'd4; #1;
    chk("pre_reset_full", {31'd0, mem_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_busy_rs", {31'd0, busy_rs}, 32'd0);
    chk("rst_busy_rt", {31'd0, busy_rt}, 32'd0);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("all_writes_seen", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
